// File: rtl/swreq.sv
// Input-port switch requester: round-robin VC selection, crossbar request
// toward the packet's output port, and credit-gated flit streaming until the tail.
module swreq #(
    parameter int DATAW = 64,
    parameter int VCH   = 2,
    parameter int PORT  = 5,
    parameter int BUFD  = 4,
    localparam int VCHW  = (VCH > 1) ? $clog2(VCH) : 1,
    localparam int PORTW = (PORT > 1) ? $clog2(PORT) : 1,
    localparam int CREDW = $clog2(BUFD + 1)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [VCH-1:0]         bvalid,
    input  logic [VCH*DATAW-1:0]   bdata,
    input  logic [VCH-1:0]         btail,
    input  logic [VCH*PORTW-1:0]   broute,
    output logic [VCH-1:0]         bpop,
    output logic                   req,
    output logic [PORTW-1:0]       port,
    input  logic [PORT-1:0]        grt,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid,
    output logic [VCHW-1:0]        ovch,
    input  logic [PORT-1:0]        cr_ret
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } state_e;

    state_e            state_q, state_d;
    logic [VCHW-1:0]   sel_q, sel_d;
    logic [VCHW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PORTW-1:0]  oport_q, oport_d;
    logic              req_q, req_d;
    logic [CREDW-1:0]  cred_q [PORT];
    logic [CREDW-1:0]  cred_d [PORT];

    logic              rrFound;
    logic [VCHW-1:0]   rrPick;
    int                rrIdx;
    logic              sendFlit;
    logic              isTail;

    // First VC with a head flit, scanning upward from the round-robin pointer.
    always_comb begin
        rrFound = 1'b0;
        rrPick  = '0;
        rrIdx   = 0;
        for (int i = 0; i < VCH; i++) begin
            rrIdx = (int'(rr_ptr_q) + i) % VCH;
            if (!rrFound && bvalid[rrIdx]) begin
                rrFound = 1'b1;
                rrPick  = VCHW'(rrIdx);
            end
        end
    end

    // Reset also masks the send so no flit is popped during a mid-packet reset.
    assign sendFlit = !rst_ && (state_q == XFER) && grt[oport_q] && bvalid[sel_q]
                      && (cred_q[oport_q] != '0);
    assign isTail   = btail[sel_q];

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            oport_q  <= '0;
            req_q    <= 1'b0;
            for (int p = 0; p < PORT; p++) begin
                cred_q[p] <= CREDW'(BUFD);
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            oport_q  <= oport_d;
            req_q    <= req_d;
            for (int p = 0; p < PORT; p++) begin
                cred_q[p] <= cred_d[p];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        oport_d  = oport_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (rrFound) begin
                    sel_d   = rrPick;
                    oport_d = broute[int'(rrPick)*PORTW +: PORTW];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (grt[oport_q]) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (sendFlit && isTail) begin
                    state_d  = IDLE;
                    rr_ptr_d = (sel_q == VCHW'(VCH - 1)) ? '0 : sel_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d != IDLE);
    end

    // A return and a send on the same port cancel; returns saturate at BUFD.
    always_comb begin
        for (int p = 0; p < PORT; p++) begin
            cred_d[p] = cred_q[p];
            if (cr_ret[p] && !(sendFlit && oport_q == PORTW'(p))) begin
                if (cred_q[p] != CREDW'(BUFD)) begin
                    cred_d[p] = cred_q[p] + 1'b1;
                end
            end else if (!cr_ret[p] && sendFlit && oport_q == PORTW'(p)) begin
                cred_d[p] = cred_q[p] - 1'b1;
            end
        end
    end

    always_comb begin
        req    = req_q;
        port   = oport_q;
        ovalid = sendFlit;
        odata  = sendFlit ? bdata[int'(sel_q)*DATAW +: DATAW] : '0;
        ovch   = sendFlit ? sel_q : '0;
        bpop   = sendFlit ? (VCH'(1) << sel_q) : '0;
    end

endmodule

// File: tb/tb_swreq.sv
// Bench for swreq: directed scenarios then random traffic, all checked against
// a packet-level model of the requester built from per-VC flit queues.
module tb_swreq;

    localparam int DATAW = 64;
    localparam int VCH   = 2;
    localparam int PORT  = 5;
    localparam int PORTW = 3;
    localparam int BUFD  = 4;

    logic                  clk = 1'b0;
    logic                  rst_;
    logic [VCH-1:0]        bvalid;
    logic [VCH*DATAW-1:0]  bdata;
    logic [VCH-1:0]        btail;
    logic [VCH*PORTW-1:0]  broute;
    logic [VCH-1:0]        bpop;
    logic                  req;
    logic [PORTW-1:0]      port;
    logic [PORT-1:0]       grt;
    logic [DATAW-1:0]      odata;
    logic                  ovalid;
    logic                  ovch;
    logic [PORT-1:0]       cr_ret;

    always #5 clk = ~clk;

    swreq #(.DATAW(DATAW), .VCH(VCH), .PORT(PORT), .BUFD(BUFD)) dut (
        .clk(clk), .rst_(rst_), .bvalid(bvalid), .bdata(bdata), .btail(btail),
        .broute(broute), .bpop(bpop), .req(req), .port(port), .grt(grt),
        .odata(odata), .ovalid(ovalid), .ovch(ovch), .cr_ret(cr_ret)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        t;
        logic [2:0]  r;
    } flit_t;

    flit_t vcq [VCH][$];

    // Model: 0 = no packet, 1 = asking for the crossbar, 2 = packet streaming.
    int mPhase = 0;
    int mVc    = 0;
    int mPort  = 0;
    int mRr    = 0;
    int mCred [PORT] = '{BUFD, BUFD, BUFD, BUFD, BUFD};

    int nChecks = 0;
    int nPass   = 0;
    int cycleNo = 0;
    int popCount = 0;
    logic prevReq = 1'b0;
    int served [$];
    int reqRise [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pushPacket(input int vc, input int route, input int len);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f.d = {$urandom, $urandom};
            f.t = (i == len - 1);
            f.r = 3'(route);
            vcq[vc].push_back(f);
        end
    endtask

    task automatic checkOutput(input logic canSend);
        logic [63:0] expData;
        expData = canSend ? vcq[mVc][0].d : 64'h0;
        check("req", req, mPhase != 0);
        check("port", port, mPort);
        check("ovalid", ovalid, canSend);
        check("odata", odata, expData);
        check("ovch", ovch, canSend ? mVc : 0);
        check("bpop", bpop, canSend ? (1 << mVc) : 0);
        if (ovalid === 1'b1) served.push_back(int'(ovch));
        if (bpop !== '0) popCount++;
        if (req === 1'b1 && prevReq !== 1'b1) reqRise.push_back(cycleNo);
        prevReq = req;
    endtask

    task automatic applyStimulus(input logic [4:0] g, input logic [4:0] cr, input logic r);
        logic  canSend;
        logic  sent;
        flit_t h;
        int    v;
        grt    = g;
        cr_ret = cr;
        rst_   = r;
        for (int k = 0; k < VCH; k++) begin
            bvalid[k] = (vcq[k].size() > 0);
            bdata[k*DATAW +: DATAW] = bvalid[k] ? vcq[k][0].d : '0;
            btail[k] = bvalid[k] ? vcq[k][0].t : 1'b0;
            broute[k*PORTW +: PORTW] = bvalid[k] ? vcq[k][0].r : '0;
        end
        @(negedge clk);
        canSend = !r && mPhase == 2 && g[mPort] && vcq[mVc].size() > 0 && mCred[mPort] > 0;
        checkOutput(canSend);
        if (r) begin
            mPhase = 0;
            mRr    = 0;
            mVc    = 0;
            mPort  = 0;
            for (int p = 0; p < PORT; p++) mCred[p] = BUFD;
        end else begin
            for (int p = 0; p < PORT; p++) begin
                sent = canSend && mPort == p;
                if (cr[p] && !sent) mCred[p] = (mCred[p] < BUFD) ? mCred[p] + 1 : BUFD;
                else if (sent && !cr[p]) mCred[p] = mCred[p] - 1;
            end
            if (mPhase == 0) begin
                for (int i = 0; i < VCH; i++) begin
                    v = (mRr + i) % VCH;
                    if (mPhase == 0 && vcq[v].size() > 0) begin
                        mVc    = v;
                        mPort  = int'(vcq[v][0].r);
                        mPhase = 1;
                    end
                end
            end else if (mPhase == 1) begin
                if (g[mPort]) mPhase = 2;
            end else if (canSend) begin
                h = vcq[mVc].pop_front();
                if (h.t) begin
                    mPhase = 0;
                    mRr    = (mVc + 1) % VCH;
                end
            end
        end
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    initial begin
        logic [4:0] g;
        logic [4:0] cr;
        logic       r;
        int         vc;

        rst_ = 1'b1; grt = '0; cr_ret = '0;
        bvalid = '0; bdata = '0; btail = '0; broute = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles while both VCs present head flits
        pushPacket(0, 2, 1);
        pushPacket(1, 4, 3);
        applyStimulus(5'b00000, 5'b00000, 1'b1);
        applyStimulus(5'b00000, 5'b00000, 1'b1);

        // Single-flit packet on VC0 toward port 2
        applyStimulus(5'b00000, 5'b00000, 1'b0);
        applyStimulus(5'b00100, 5'b00000, 1'b0);
        applyStimulus(5'b00100, 5'b00000, 1'b0);
        applyStimulus(5'b00000, 5'b00000, 1'b0);

        // Three-flit packet on VC1 with an alternating grant on port 4
        popCount = 0;
        applyStimulus(5'b10000, 5'b00000, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus((k % 2 == 1) ? 5'b10000 : 5'b00000, 5'b00000, 1'b0);
        applyStimulus(5'b00000, 5'b00000, 1'b0);
        check("altPops", popCount, 3);
        for (int k = 0; k < 3; k++) applyStimulus(5'b00000, 5'b10100, 1'b0);

        // Credit exhaustion on port 1, then return and coincident return+send
        pushPacket(1, 1, 6);
        for (int k = 0; k < 8; k++) applyStimulus(5'b00010, 5'b00000, 1'b0);
        applyStimulus(5'b00010, 5'b00010, 1'b0);
        applyStimulus(5'b00010, 5'b00000, 1'b0);
        applyStimulus(5'b00010, 5'b00010, 1'b0);
        applyStimulus(5'b00010, 5'b00010, 1'b0);
        pushPacket(1, 1, 2);
        for (int k = 0; k < 5; k++) applyStimulus(5'b00010, 5'b00000, 1'b0);
        applyStimulus(5'b00010, 5'b00010, 1'b0);
        applyStimulus(5'b00010, 5'b00000, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(5'b00000, 5'b00010, 1'b0);

        // Round-robin between two VCs with queued single-flit packets
        pushPacket(0, 0, 1); pushPacket(0, 0, 1);
        pushPacket(1, 3, 1); pushPacket(1, 3, 1);
        served.delete();
        reqRise.delete();
        for (int k = 0; k < 12; k++) applyStimulus(5'b11111, 5'b00000, 1'b0);
        check("rrCount", served.size(), 4);
        for (int i = 0; i < served.size(); i++) check("rrOrder", served[i], i % 2);
        for (int i = 0; i + 1 < reqRise.size(); i++) check("rrReqGap", reqRise[i+1] - reqRise[i], 3);
        for (int k = 0; k < 2; k++) applyStimulus(5'b00000, 5'b01001, 1'b0);

        // Reset after the second flit of a four-flit packet
        pushPacket(0, 3, 4);
        for (int k = 0; k < 4; k++) applyStimulus(5'b01000, 5'b00000, 1'b0);
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        vcq[0].delete();
        pushPacket(1, 3, 4);
        for (int k = 0; k < 7; k++) applyStimulus(5'b01000, 5'b00000, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(5'b00000, 5'b01000, 1'b0);

        // Random traffic, grants, credit returns and occasional reset
        for (int c = 0; c < 800; c++) begin
            vc = int'($urandom_range(0, VCH - 1));
            if (vcq[vc].size() < 6 && $urandom_range(0, 5) == 0)
                pushPacket(vc, int'($urandom_range(0, PORT - 1)), int'($urandom_range(1, 5)));
            g = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) g[mPort] = 1'b1;
            cr = '0;
            for (int p = 0; p < PORT; p++) cr[p] = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) == 0);
            applyStimulus(g, cr, r);
            if (r) begin
                vcq[0].delete();
                vcq[1].delete();
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
